fbc_motor_ctrl: RTL and testbench

//  Sequencer for the motor overload path. Qualifies motor_Ufeed samples against a threshold with

---
 rtl/fbc_motor_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_fbc_motor_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbc_motor_ctrl.sv
// Motor overload sequencer: debounces |Ufeed| against a threshold, drives the
// fbc_motor overload enable and latches a fault when the Ufeed strobe stops.
// Ports: clk_i, rst_n_i (async, active low), ctrl_enable_i, motor_state_i,
//   motor_Ufeed_en_i/motor_Ufeed_i (sample strobe/value), overload_ufeed_thre_i,
//   fault_clear_i -> overload_motor_en_o, ctrl_state_o, sample_timeout_o.
// Optional FBC_MOTOR_CTRL_STAT_EN adds overload_evt_cnt_o (OVERLOAD entries).
module fbc_motor_ctrl #(
  parameter logic [2:0] RUN_STATE   = 3'd2,
  parameter int         ARM_SAMPLES = 4,
  parameter int         TRIP_CNT    = 8,
  parameter int         RELEASE_CNT = 16,
  parameter int         HOLDOFF_CYC = 256,
  parameter int         WDOG_CYC    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ctrl_enable_i,
  input  logic [2:0]  motor_state_i,
  input  logic        motor_Ufeed_en_i,
  input  logic [15:0] motor_Ufeed_i,
  input  logic [15:0] overload_ufeed_thre_i,
  input  logic        fault_clear_i,
  output logic        overload_motor_en_o,
  output logic [2:0]  ctrl_state_o,
  output logic        sample_timeout_o
`ifdef FBC_MOTOR_CTRL_STAT_EN
  ,
  output logic [15:0] overload_evt_cnt_o
`endif
);

  localparam int AW = $clog2(ARM_SAMPLES + 1);
  localparam int TW = $clog2(TRIP_CNT + 1);
  localparam int RW = $clog2(RELEASE_CNT + 1);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam int WW = $clog2(WDOG_CYC + 1);

  localparam logic [AW-1:0] ARM_N  = AW'(ARM_SAMPLES);
  localparam logic [TW-1:0] TRIP_N = TW'(TRIP_CNT);
  localparam logic [RW-1:0] REL_N  = RW'(RELEASE_CNT);
  localparam logic [HW-1:0] HOLD_L = HW'(HOLDOFF_CYC - 1);
  localparam logic [WW-1:0] WD_L   = WW'(WDOG_CYC - 1);
  localparam logic [AW-1:0] A1 = AW'(1);
  localparam logic [TW-1:0] T1 = TW'(1);
  localparam logic [RW-1:0] R1 = RW'(1);
  localparam logic [HW-1:0] H1 = HW'(1);
  localparam logic [WW-1:0] W1 = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_MONITOR  = 3'd2,
    S_OVERLOAD = 3'd3,
    S_RECOVER  = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [TW-1:0] trip_q, trip_d, trip_inc;
  logic [RW-1:0] rel_q, rel_d, rel_inc;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          en_q, to_q;
  logic [15:0]   mag;
  logic          over, run, strobe;

  // |x| with the most negative code clamped to 16'h7FFF
  always_comb begin
    mag = motor_Ufeed_i;
    if (motor_Ufeed_i == 16'h8000) mag = 16'h7FFF;
    else if (motor_Ufeed_i[15])    mag = -motor_Ufeed_i;
  end

  assign over     = (mag >= overload_ufeed_thre_i);
  assign run      = ctrl_enable_i && (motor_state_i == RUN_STATE);
  assign strobe   = motor_Ufeed_en_i;
  assign trip_inc = (trip_q == TRIP_N) ? trip_q : trip_q + T1;
  assign rel_inc  = (rel_q == REL_N) ? rel_q : rel_q + R1;

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    trip_d  = trip_q;
    rel_d   = rel_q;
    hold_d  = hold_q;
    wdog_d  = wdog_q;
    if (state_q == S_FAULT) begin
      wdog_d = '0;
      if (fault_clear_i) state_d = S_IDLE;
    end else if (!run) begin
      state_d = S_IDLE;
      arm_d   = '0;
      trip_d  = '0;
      rel_d   = '0;
      hold_d  = '0;
      wdog_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          arm_d   = '0;
          trip_d  = '0;
          rel_d   = '0;
          hold_d  = '0;
          wdog_d  = '0;
        end
        S_ARM, S_MONITOR, S_OVERLOAD: begin
          // expiry beats a strobe landing in the same cycle
          if (wdog_q == WD_L) begin
            state_d = S_FAULT;
            wdog_d  = '0;
          end else if (!strobe) begin
            wdog_d = wdog_q + W1;
          end else begin
            wdog_d = '0;
            case (state_q)
              S_ARM: begin
                arm_d = arm_q + A1;
                if (arm_q + A1 == ARM_N) begin
                  state_d = S_MONITOR;
                  arm_d   = '0;
                  trip_d  = '0;
                end
              end
              S_MONITOR: begin
                trip_d = over ? trip_inc : '0;
                if (over && trip_inc == TRIP_N) begin
                  state_d = S_OVERLOAD;
                  rel_d   = '0;
                end
              end
              default: begin
                rel_d = over ? '0 : rel_inc;
                if (!over && rel_inc == REL_N) begin
                  state_d = S_RECOVER;
                  hold_d  = '0;
                end
              end
            endcase
          end
        end
        S_RECOVER: begin
          wdog_d = '0;
          if (hold_q == HOLD_L) begin
            state_d = S_MONITOR;
            hold_d  = '0;
            trip_d  = '0;
          end else begin
            hold_d = hold_q + H1;
          end
        end
        default: begin
          state_d = S_IDLE;
          arm_d   = '0;
          trip_d  = '0;
          rel_d   = '0;
          hold_d  = '0;
          wdog_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      arm_q   <= '0;
      trip_q  <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
      wdog_q  <= '0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      trip_q  <= trip_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      wdog_q  <= wdog_d;
      en_q    <= (state_d == S_OVERLOAD);
      to_q    <= (state_d == S_FAULT);
    end
  end

  assign overload_motor_en_o = en_q;
  assign ctrl_state_o        = state_q;
  assign sample_timeout_o    = to_q;

`ifdef FBC_MOTOR_CTRL_STAT_EN
  logic [15:0] evt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      evt_q <= '0;
    end else if (fault_clear_i) begin
      evt_q <= '0;
    end else if (state_q != S_OVERLOAD && state_d == S_OVERLOAD
                 && evt_q != 16'hFFFF) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign overload_evt_cnt_o = evt_q;
`endif

endmodule

// File: tb/tb_fbc_motor_ctrl.sv
// Bench for fbc_motor_ctrl: randomized/directed stimulus, reference model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_fbc_motor_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ctrl_enable_i = 1'b0;
  logic [2:0]  motor_state_i = 3'd0;
  logic        motor_Ufeed_en_i = 1'b0;
  logic [15:0] motor_Ufeed_i = 16'd0;
  logic [15:0] overload_ufeed_thre_i = 16'd13107;
  logic        fault_clear_i = 1'b0;
  logic        overload_motor_en_o;
  logic [2:0]  ctrl_state_o;
  logic        sample_timeout_o;
`ifdef FBC_MOTOR_CTRL_STAT_EN
  logic [15:0] overload_evt_cnt_o;
`endif

  fbc_motor_ctrl dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .ctrl_enable_i(ctrl_enable_i),
    .motor_state_i(motor_state_i),
    .motor_Ufeed_en_i(motor_Ufeed_en_i),
    .motor_Ufeed_i(motor_Ufeed_i),
    .overload_ufeed_thre_i(overload_ufeed_thre_i),
    .fault_clear_i(fault_clear_i),
    .overload_motor_en_o(overload_motor_en_o),
    .ctrl_state_o(ctrl_state_o),
    .sample_timeout_o(sample_timeout_o)
`ifdef FBC_MOTOR_CTRL_STAT_EN
    ,
    .overload_evt_cnt_o(overload_evt_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int st;
    bit en;
    bit to;
    int evt;
  } exp_t;

  exp_t exp_q[$];

  // reference model: mode number plus plain event tallies
  int m_st = 0;
  int m_armed = 0;
  int m_overs = 0;
  int m_unders = 0;
  int m_rec = 0;
  int m_quiet = 0;
  int m_evt = 0;

  function automatic int magnitude(input logic [15:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  function automatic logic [15:0] pick(input bit want_over);
    int m;
    if (want_over && $urandom_range(9, 0) == 0) return 16'h8000;
    m = want_over ? $urandom_range(32767, 13107) : $urandom_range(13106, 0);
    if ($urandom_range(1, 0) == 1) m = -m;
    return 16'(m);
  endfunction

  task automatic model(input bit rst, input bit en, input logic [2:0] ms,
                       input bit stb, input logic [15:0] v, input bit clr);
    int nxt;
    bit run;
    bit over;
    exp_t e;
    if (rst) begin
      m_st = 0; m_armed = 0; m_overs = 0; m_unders = 0;
      m_rec = 0; m_quiet = 0; m_evt = 0;
      nxt = 0;
    end else begin
      run  = en && (ms == 3'd2);
      over = magnitude(v) >= int'(overload_ufeed_thre_i);
      nxt  = m_st;
      if (m_st == 5) begin
        if (clr) nxt = 0;
      end else if (!run) begin
        nxt = 0;
      end else if (m_st == 0) begin
        nxt = 1; m_armed = 0; m_quiet = 0;
      end else if (m_st == 4) begin
        m_rec++;
        if (m_rec == 256) begin
          nxt = 2; m_overs = 0; m_quiet = 0;
        end
      end else if (m_quiet + 1 >= 1024) begin
        nxt = 5;
      end else if (!stb) begin
        m_quiet++;
      end else begin
        m_quiet = 0;
        if (m_st == 1) begin
          m_armed++;
          if (m_armed == 4) begin nxt = 2; m_overs = 0; end
        end else if (m_st == 2) begin
          m_overs = over ? m_overs + 1 : 0;
          if (m_overs == 8) begin nxt = 3; m_unders = 0; end
        end else begin
          m_unders = over ? 0 : m_unders + 1;
          if (m_unders == 16) begin nxt = 4; m_rec = 0; end
        end
      end
      if (clr) m_evt = 0;
      else if (nxt == 3 && m_st != 3 && m_evt < 65535) m_evt++;
      m_st = nxt;
    end
    e.st  = nxt;
    e.en  = (nxt == 3);
    e.to  = (nxt == 5);
    e.evt = m_evt;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [2:0] ms,
                     input bit stb, input logic [15:0] v, input bit clr);
    bit was_high;
    @(negedge clk_i);
    was_high = rst_n_i;
    rst_n_i = !rst;
    ctrl_enable_i = en;
    motor_state_i = ms;
    motor_Ufeed_en_i = stb;
    motor_Ufeed_i = v;
    fault_clear_i = clr;
    model(rst, en, ms, stb, v, clr);
    if (rst && was_high) begin
      #1;
      checks++;
      if (ctrl_state_o !== 3'd0 || overload_motor_en_o !== 1'b0
          || sample_timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL async_reset state=%0d en=%0b to=%0b want 0/0/0",
                 ctrl_state_o, overload_motor_en_o, sample_timeout_o);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 3'd2, 0, 16'd0, 0);
  endtask

  task automatic strb(input logic [15:0] v);
    cyc(0, 1, 3'd2, 1, v, 0);
  endtask

  task automatic strb_gap(input logic [15:0] v);
    idle($urandom_range(3, 0));
    strb(v);
  endtask

  // monitor: one comparison per cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ctrl_state_o !== 3'(e.st) || overload_motor_en_o !== e.en
            || sample_timeout_o !== e.to
`ifdef FBC_MOTOR_CTRL_STAT_EN
            || overload_evt_cnt_o !== 16'(e.evt)
`endif
           ) begin
          errors++;
          $display("FAIL outputs t=%0t state=%0d en=%0b to=%0b want %0d/%0b/%0b",
                   $time, ctrl_state_o, overload_motor_en_o,
                   sample_timeout_o, e.st, e.en, e.to);
        end
      end
    end
  end

  initial begin
    int n;
    bit en;
    logic [2:0] ms;
    // reset held, then idle with enable low
    repeat (3) cyc(1, 0, 3'd0, 0, 16'd0, 0);
    repeat (2) cyc(0, 0, 3'd2, 1, 16'd20000, 1);
    // arm, trip debounce with an interrupting under sample
    idle(1);
    repeat (4) strb_gap(16'($urandom));
    repeat (7) strb_gap(16'd20000);
    strb_gap(16'd100);
    repeat (7) strb_gap(16'd20000);
    strb(pick(1));
    // release debounce with a reset of the run
    repeat (10) strb_gap(pick(0));
    strb(pick(1));
    repeat (16) strb_gap(16'd100);
    // holdoff: strobes ignored, then back to monitor
    for (int i = 0; i < 255; i++)
      cyc(0, 1, 3'd2, $urandom_range(3, 0) == 0, pick(1), 0);
    idle(5);
    repeat (8) strb_gap(16'h8000);
    idle(3);
    // motor stops mid-overload
    cyc(0, 1, 3'd0, 0, 16'd0, 0);
    idle(1);
    repeat (4) strb_gap(pick(0));
    // watchdog: 1023-cycle spacing survives, silence faults
    strb(pick(0));
    idle(1022);
    strb(pick(0));
    idle(1030);
    repeat (3) cyc(0, 0, 3'd0, 0, 16'd0, 0);
    cyc(0, 1, 3'd2, 0, 16'd0, 1);
    idle(2);
    // randomized phase
    n = 0;
    while (n < 4000) begin
      if ($urandom_range(1499, 0) == 0) begin
        idle($urandom_range(1030, 1020));
      end
      en = ($urandom_range(399, 0) != 0);
      ms = ($urandom_range(399, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'd2;
      cyc(0, en, ms, $urandom_range(2, 0) == 0,
          pick($urandom_range(3, 0) != 0), $urandom_range(199, 0) == 0);
      n++;
    end
    // reach overload, then reset mid-operation
    cyc(0, 1, 3'd2, 0, 16'd0, 1);
    cyc(0, 0, 3'd2, 0, 16'd0, 0);
    idle(1);
    repeat (4) strb_gap(pick(0));
    repeat (8) strb_gap(pick(1));
    idle(2);
    repeat (2) cyc(1, 1, 3'd2, 1, pick(1), 0);
    idle(2);
    // three overload entries, then the clear pulse
    repeat (4) strb_gap(pick(0));
    for (int k = 0; k < 3; k++) begin
      repeat (8) strb_gap(pick(1));
      repeat (16) strb_gap(pick(0));
      idle(257);
    end
    cyc(0, 1, 3'd2, 0, 16'd0, 1);
    idle(3);
    // drain the scoreboard within a bounded number of cycles
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk_i);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
